fetch_sequencer: RTL and testbench

Run/load controller for the instruction-fetch stage. It shares the instruction memory between the debug program loader (write port) and the fetch path (read address). It sequences the PC through idle, load, free-run, single-step and halted states. It drives the fetch stage's stall input and a one-cycle PC-clear pulse, so programs can be loaded, run and stepped without resetting the pipeline.

---
 rtl/fetch_sequencer.sv | 147 ++++++++++++++
 tb/tb_fetch_sequencer.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// fetch_sequencer
// Run/load controller for the instruction-fetch stage. It arbitrates the
// instruction memory between the debug program loader (writes) and the fetch
// path (read address). It walks through IDLE, LOAD, RUN, STEP and HALTED, and
// drives the fetch stall and a one-cycle PC-clear pulse.
//
// Ports
//   clk, reset            clock; asynchronous active-low reset
//   i_load_start/done     open / close a load session
//   i_load_valid/addr/data, o_load_ready   loader word handshake (byte address)
//   i_run, i_step         free-run and single-step commands
//   i_halt_seen           HALT reached the pipeline
//   i_fetch_pc            fetch-stage PC (read address outside LOAD)
//   o_mem_we/addr/wdata   instruction memory port
//   o_fetch_stall         registered PC hold
//   o_pc_clear            registered one-cycle PC reload pulse
//   o_state               IDLE=0 LOAD=1 RUN=2 STEP=3 HALTED=4
//   o_load_count          words written this session (saturating)
//   o_load_error          sticky rejected-write flag
//   o_run_cycles          stall-free cycles since the last load start
module fetch_sequencer #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_load_start,
  input  logic                  i_load_done,
  input  logic                  i_load_valid,
  output logic                  o_load_ready,
  input  logic [31:0]           i_load_addr,
  input  logic [DATA_WIDTH-1:0] i_load_data,
  input  logic                  i_run,
  input  logic                  i_step,
  input  logic                  i_halt_seen,
  input  logic [31:0]           i_fetch_pc,
  output logic                  o_mem_we,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [DATA_WIDTH-1:0] o_mem_wdata,
  output logic                  o_fetch_stall,
  output logic                  o_pc_clear,
  output logic [2:0]            o_state,
  output logic [ADDR_WIDTH:0]   o_load_count,
  output logic                  o_load_error,
  output logic [31:0]           o_run_cycles
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LOAD   = 3'd1;
  localparam logic [2:0] ST_RUN    = 3'd2;
  localparam logic [2:0] ST_STEP   = 3'd3;
  localparam logic [2:0] ST_HALTED = 3'd4;

  localparam logic [ADDR_WIDTH:0] COUNT_MAX = {1'b1, {ADDR_WIDTH{1'b0}}};

  logic [2:0]          state;
  logic [2:0]          state_nxt;
  logic                step_prev;
  logic                step_rise;
  logic                addr_ok;
  logic                wr_accept;
  logic                session_start;
  logic                load_exit_p1;
  logic                stall_q;
  logic                pc_clear_q;
  logic [ADDR_WIDTH:0] load_count;
  logic                load_error;
  logic [31:0]         run_cycles;

  // Only the word-address bits of the fetch PC select a memory word.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{i_fetch_pc[31:ADDR_WIDTH+2], i_fetch_pc[1:0]};

  assign step_rise     = i_step & ~step_prev;
  assign addr_ok       = (i_load_addr[1:0] == 2'b00) &&
                         ((i_load_addr >> (ADDR_WIDTH + 2)) == 32'd0);
  assign wr_accept     = (state == ST_LOAD) && i_load_valid && addr_ok;
  assign session_start = ((state == ST_IDLE) || (state == ST_HALTED)) && i_load_start;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (i_load_start)   state_nxt = ST_LOAD;
        else if (i_run)     state_nxt = ST_RUN;
        else if (step_rise) state_nxt = ST_STEP;
      end
      ST_LOAD:   if (i_load_done) state_nxt = ST_IDLE;
      ST_RUN:    if (i_halt_seen) state_nxt = ST_HALTED;
      ST_STEP:   state_nxt = i_halt_seen ? ST_HALTED : ST_IDLE;
      ST_HALTED: if (i_load_start) state_nxt = ST_LOAD;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Stage p0: state, session counters and step edge detector
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      step_prev  <= 1'b0;
      load_count <= '0;
      load_error <= 1'b0;
      run_cycles <= 32'd0;
    end else begin
      state     <= state_nxt;
      step_prev <= i_step;
      if (session_start) begin
        load_count <= '0;
        load_error <= 1'b0;
        run_cycles <= 32'd0;
      end else begin
        if (wr_accept && (load_count != COUNT_MAX))
          load_count <= load_count + (ADDR_WIDTH+1)'(1);
        if ((state == ST_LOAD) && i_load_valid && !addr_ok)
          load_error <= 1'b1;
        if ((state == ST_RUN) || (state == ST_STEP))
          run_cycles <= run_cycles + 32'd1;
      end
    end
  end

  // Stage p1: stall and PC-clear lag the state by one cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_q      <= 1'b1;
      load_exit_p1 <= 1'b0;
      pc_clear_q   <= 1'b0;
    end else begin
      stall_q      <= !((state == ST_RUN) || (state == ST_STEP));
      load_exit_p1 <= (state == ST_LOAD) && i_load_done;
      pc_clear_q   <= load_exit_p1;
    end
  end

  assign o_load_ready  = (state == ST_LOAD);
  assign o_mem_we      = wr_accept;
  assign o_mem_addr    = (state == ST_LOAD) ? i_load_addr[ADDR_WIDTH+1:2]
                                            : i_fetch_pc[ADDR_WIDTH+1:2];
  assign o_mem_wdata   = (state == ST_LOAD) ? i_load_data : '0;
  assign o_fetch_stall = stall_q;
  assign o_pc_clear    = pc_clear_q;
  assign o_state       = state;
  assign o_load_count  = load_count;
  assign o_load_error  = load_error;
  assign o_run_cycles  = run_cycles;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Testbench for fetch_sequencer: directed stimulus, a behavioural model that
// tracks the sequencer from its command rules, a per-cycle comparison of all
// outputs, and literal expectations at the points of interest.
module tb_fetch_sequencer;
  localparam int AW = 8;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          load_start = 1'b0, load_done = 1'b0, load_valid = 1'b0;
  logic          load_ready;
  logic [31:0]   load_addr = 32'd0;
  logic [DW-1:0] load_data = '0;
  logic          run = 1'b0, step = 1'b0, halt = 1'b0;
  logic [31:0]   fetch_pc = 32'h0000_0100;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          fetch_stall, pc_clear, load_error;
  logic [2:0]    state;
  logic [AW:0]   load_count;
  logic [31:0]   run_cycles;

  fetch_sequencer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .reset(reset),
    .i_load_start(load_start), .i_load_done(load_done),
    .i_load_valid(load_valid), .o_load_ready(load_ready),
    .i_load_addr(load_addr), .i_load_data(load_data),
    .i_run(run), .i_step(step), .i_halt_seen(halt),
    .i_fetch_pc(fetch_pc),
    .o_mem_we(mem_we), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
    .o_fetch_stall(fetch_stall), .o_pc_clear(pc_clear),
    .o_state(state), .o_load_count(load_count),
    .o_load_error(load_error), .o_run_cycles(run_cycles)
  );

  always #5 clk = ~clk;

  // Behavioural model: 0 IDLE, 1 LOAD, 2 RUN, 3 STEP, 4 HALTED
  int          ms, h1, h2;
  logic [AW:0] mcnt;
  logic        merr;
  logic [31:0] mrun;
  logic        mprev;

  function automatic bit good_addr(input logic [31:0] a);
    return (a % 4 == 0) && (a < (32'd1 << (AW + 2)));
  endfunction

  function automatic int next_state(input int s);
    if (s == 0) return load_start ? 1 : run ? 2 : (step && !mprev) ? 3 : 0;
    if (s == 1) return load_done ? 0 : 1;
    if (s == 2) return halt ? 4 : 2;
    if (s == 3) return halt ? 4 : 0;
    return load_start ? 1 : 4;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      ms <= 0; h1 <= 0; h2 <= 0;
      mcnt <= '0; merr <= 1'b0; mrun <= 32'd0; mprev <= 1'b0;
    end else begin
      ms <= next_state(ms);
      h1 <= ms;
      h2 <= h1;
      mprev <= step;
      if ((ms == 0 || ms == 4) && load_start) begin
        mcnt <= '0; merr <= 1'b0; mrun <= 32'd0;
      end else begin
        if (ms == 1 && load_valid) begin
          if (!good_addr(load_addr)) merr <= 1'b1;
          else if (mcnt < (AW+1)'(1 << AW)) mcnt <= mcnt + 1'b1;
        end
        if (ms == 2 || ms == 3) mrun <= mrun + 32'd1;
      end
    end
  end

  int n_cmp = 0;
  int n_fail = 0;
  int nwe = 0, npc = 0, nfree = 0;
  logic [AW-1:0] wlog [0:511];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    bit exp_we;
    exp_we = (ms == 1) && load_valid && good_addr(load_addr);
    chk("state", 64'(state), 64'(ms));
    chk("stall", 64'(fetch_stall), 64'(!(h1 == 2 || h1 == 3)));
    chk("pc_clear", 64'(pc_clear), 64'(h2 == 1 && h1 == 0));
    chk("load_count", 64'(load_count), 64'(mcnt));
    chk("load_error", 64'(load_error), 64'(merr));
    chk("run_cycles", 64'(run_cycles), 64'(mrun));
    chk("load_ready", 64'(load_ready), 64'(ms == 1));
    chk("mem_we", 64'(mem_we), 64'(exp_we));
    if (ms != 1) begin
      chk("rd_addr", 64'(mem_addr), 64'((fetch_pc >> 2) % (1 << AW)));
      chk("rd_wdata", 64'(mem_wdata), 64'd0);
    end else if (exp_we) begin
      chk("wr_addr", 64'(mem_addr), 64'((load_addr >> 2) % (1 << AW)));
      chk("wr_data", 64'(mem_wdata), 64'(load_data));
    end
    if (mem_we) begin
      if (nwe < 512) wlog[nwe] = mem_addr;
      nwe++;
    end
    if (pc_clear) npc++;
    if (!fetch_stall) nfree++;
  endtask

  task automatic cyc();
    @(negedge clk);
    compare_all();
    @(posedge clk);
    #1;
    fetch_pc = fetch_pc + 32'h0000_0404;
  endtask

  initial begin
    // Reset asserted mid-cycle, then released mid-cycle
    #3 reset = 1'b0;
    #1;
    chk("rst_state", 64'(state), 64'd0);
    chk("rst_stall", 64'(fetch_stall), 64'd1);
    chk("rst_pc_clear", 64'(pc_clear), 64'd0);
    chk("rst_count", 64'(load_count), 64'd0);
    chk("rst_error", 64'(load_error), 64'd0);
    chk("rst_runs", 64'(run_cycles), 64'd0);
    cyc(); cyc();
    reset = 1'b1;
    cyc();
    chk("rel_state", 64'(state), 64'd0);
    chk("rel_stall", 64'(fetch_stall), 64'd1);
    chk("rel_count", 64'(load_count), 64'd0);

    // Two-word load, then done
    nwe = 0; npc = 0;
    load_start = 1; cyc(); load_start = 0;
    load_valid = 1; load_addr = 32'h0; load_data = 32'h2001_0005; cyc();
    load_addr = 32'h4; load_data = 32'h2002_0007; cyc();
    load_valid = 0; load_done = 1; cyc(); load_done = 0;
    chk("ld_exit_state", 64'(state), 64'd0);
    chk("ld_clear_early", 64'(pc_clear), 64'd0);
    cyc();
    chk("ld_clear_pulse", 64'(pc_clear), 64'd1);
    cyc();
    chk("ld_clear_end", 64'(pc_clear), 64'd0);
    chk("ld_we_pulses", 64'(nwe), 64'd2);
    chk("ld_addr0", 64'(wlog[0]), 64'd0);
    chk("ld_addr1", 64'(wlog[1]), 64'd1);
    chk("ld_count", 64'(load_count), 64'd2);
    chk("ld_pc_clears", 64'(npc), 64'd1);

    // Misaligned / out-of-range words, commands ignored in LOAD
    nwe = 0;
    load_start = 1; cyc(); load_start = 0;
    load_valid = 1; load_addr = 32'h8; load_data = 32'h1111_1111; cyc();
    load_addr = 32'h6; cyc();
    load_addr = 32'h400; cyc();
    load_addr = 32'h8000_0000; cyc();
    load_valid = 0; run = 1; halt = 1; step = 1; cyc(); run = 0; halt = 0; step = 0;
    chk("err_count", 64'(load_count), 64'd1);
    chk("err_flag", 64'(load_error), 64'd1);
    chk("err_we_pulses", 64'(nwe), 64'd1);
    chk("err_state", 64'(state), 64'd1);
    load_done = 1; cyc(); load_done = 0; cyc(); cyc();
    load_start = 1; cyc(); load_start = 0;
    chk("err_cleared", 64'(load_error), 64'd0);
    chk("err_count_clr", 64'(load_count), 64'd0);

    // Count saturation at 2^AW
    nwe = 0;
    load_valid = 1;
    for (int i = 0; i < 258; i++) begin
      load_addr = 32'((i % 256) * 4);
      load_data = 32'(i);
      cyc();
    end
    load_valid = 0;
    chk("sat_count", 64'(load_count), 64'd256);
    chk("sat_we_pulses", 64'(nwe), 64'd258);
    load_done = 1; cyc(); load_done = 0; cyc(); cyc();

    // Single step held, released and reasserted
    nfree = 0;
    step = 1; repeat (5) cyc(); step = 0; repeat (3) cyc();
    chk("step1_free", 64'(nfree), 64'd1);
    chk("step1_runs", 64'(run_cycles), 64'd1);
    chk("step1_state", 64'(state), 64'd0);
    step = 1; repeat (2) cyc(); step = 0; repeat (3) cyc();
    chk("step2_free", 64'(nfree), 64'd2);
    chk("step2_runs", 64'(run_cycles), 64'd2);

    // Free run, halt after 10 cycles
    load_start = 1; cyc(); load_start = 0;
    load_done = 1; cyc(); load_done = 0; cyc(); cyc();
    nfree = 0;
    run = 1; cyc(); run = 0;
    repeat (4) cyc();
    load_start = 1; cyc(); load_start = 0;
    repeat (4) cyc();
    halt = 1; cyc(); halt = 0;
    chk("run_halted", 64'(state), 64'd4);
    repeat (2) cyc();
    chk("run_cycles10", 64'(run_cycles), 64'd10);
    chk("run_stall", 64'(fetch_stall), 64'd1);
    chk("run_free", 64'(nfree), 64'd10);
    run = 1; repeat (3) cyc(); run = 0;
    step = 1; cyc(); step = 0; cyc();
    chk("halt_ignores", 64'(state), 64'd4);
    chk("halt_runs", 64'(run_cycles), 64'd10);

    // Word and done together, starting from HALTED
    nwe = 0; npc = 0;
    load_start = 1; cyc(); load_start = 0;
    chk("hl_state", 64'(state), 64'd1);
    chk("hl_runs_clr", 64'(run_cycles), 64'd0);
    load_valid = 1; load_done = 1; load_addr = 32'h10; load_data = 32'hCAFE_0001; cyc();
    load_valid = 0; load_done = 0;
    chk("wd_state", 64'(state), 64'd0);
    chk("wd_we", 64'(nwe), 64'd1);
    chk("wd_addr", 64'(wlog[0]), 64'd4);
    chk("wd_count", 64'(load_count), 64'd1);
    cyc();
    chk("wd_clear", 64'(pc_clear), 64'd1);
    cyc();
    chk("wd_clears", 64'(npc), 64'd1);

    // Step with HALT seen in the step cycle
    step = 1; cyc(); step = 0; halt = 1; cyc(); halt = 0; cyc();
    chk("sh_state", 64'(state), 64'd4);
    chk("sh_runs", 64'(run_cycles), 64'd1);

    // Reset in the middle of a load session
    load_start = 1; cyc(); load_start = 0;
    load_valid = 1; load_addr = 32'h20; load_data = 32'h55; cyc();
    chk("rl_count1", 64'(load_count), 64'd1);
    load_addr = 32'h24;
    #2 reset = 1'b0;
    #1;
    chk("rl_state", 64'(state), 64'd0);
    chk("rl_count", 64'(load_count), 64'd0);
    chk("rl_stall", 64'(fetch_stall), 64'd1);
    chk("rl_we", 64'(mem_we), 64'd0);
    cyc();
    reset = 1'b1; load_valid = 0;
    cyc(); cyc();
    chk("rl_after", 64'(state), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
